// File: rtl/pc_fetch_gen.sv
`timescale 1ns/1ps
// Fetch PC register and request generator with pending branch/trap redirect capture.
// One request per cycle when req_ready is high; an issued request holds until accepted, and stall only blocks the next one.
module pc_fetch_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              PC_INC     = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_nxt,
    output logic            flush,
    output logic            misalign
);

    localparam logic [XLEN-1:0] INC        = XLEN'(PC_INC);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << ALIGN_BITS;

    typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;

    state_t          state;
    state_t          state_next;
    logic            pend_vld;
    logic            pend_trap;
    logic [XLEN-1:0] pend_pc;

    logic            accept;
    logic            tgt_vld;
    logic [XLEN-1:0] tgt_pc;
    logic            load_tgt;
    logic            load_seq;
    logic            pend_clr;
    logic            pend_capture;

    assign req_valid = (state == FETCH);
    assign req_pc    = pc;
    assign pc_nxt    = pc + INC;
    assign accept    = req_valid & req_ready;

    // Arriving trap > pending trap > arriving redirect > pending redirect.
    always_comb begin
        tgt_vld = 1'b1;
        tgt_pc  = trap_pc;
        if (trap_en) begin
            tgt_pc = trap_pc;
        end else if (pend_vld && pend_trap) begin
            tgt_pc = pend_pc;
        end else if (redirect_en) begin
            tgt_pc = redirect_pc;
        end else if (pend_vld) begin
            tgt_pc = pend_pc;
        end else begin
            tgt_vld = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Pending entries only exist in FETCH, so BOOT/WAIT see arrivals alone.
    always_comb begin
        state_next   = state;
        load_tgt     = 1'b0;
        load_seq     = 1'b0;
        pend_clr     = 1'b0;
        pend_capture = 1'b0;
        case (state)
            BOOT: begin
                state_next = stall ? WAIT : FETCH;
                load_tgt   = tgt_vld;
            end
            FETCH: begin
                if (accept) begin
                    state_next = stall ? WAIT : FETCH;
                    load_tgt   = tgt_vld;
                    load_seq   = ~tgt_vld;
                    pend_clr   = 1'b1;
                end else begin
                    pend_capture = trap_en | (redirect_en & ~(pend_vld & pend_trap));
                end
            end
            WAIT: begin
                if (!stall) begin
                    state_next = FETCH;
                end
                load_tgt = tgt_vld;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_VEC;
            pend_vld  <= 1'b0;
            pend_trap <= 1'b0;
            pend_pc   <= '0;
            flush     <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            flush    <= redirect_en | trap_en;
            misalign <= load_tgt & (|(tgt_pc & ~ALIGN_MASK));
            if (load_tgt) begin
                pc <= tgt_pc & ALIGN_MASK;
            end else if (load_seq) begin
                pc <= pc_nxt;
            end
            if (pend_clr) begin
                pend_vld  <= 1'b0;
                pend_trap <= 1'b0;
            end else if (pend_capture) begin
                pend_vld  <= 1'b1;
                pend_trap <= trap_en;
                pend_pc   <= trap_en ? trap_pc : redirect_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_gen.sv
`timescale 1ns/1ps
// Directed walk through the fetch scenarios, then random traffic, all against a request-level reference model.
module tb_pc_fetch_gen;

    localparam int XLEN = 32;
    localparam int ALGN = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            redirect_en;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_en;
    logic [XLEN-1:0] trap_pc;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic            flush;
    logic            misalign;

    always #5 clk = ~clk;

    pc_fetch_gen #(
        .XLEN(32), .RESET_VEC(32'h0), .PC_INC(4), .ALIGN_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .trap_en(trap_en), .trap_pc(trap_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
        .pc(pc), .pc_nxt(pc_nxt), .flush(flush), .misalign(misalign)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an outstanding-request flag, the fetch address and one held redirect.
    bit          m_req;
    logic [31:0] m_pc;
    bit          m_pend;
    bit          m_pend_trap;
    logic [31:0] m_pend_tgt;
    bit          m_flush;
    bit          m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_req = 0; m_pc = 32'h0; m_pend = 0; m_pend_trap = 0;
        m_pend_tgt = 32'h0; m_flush = 0; m_mis = 0;
    endtask

    task automatic model_step();
        bit          has;
        logic [31:0] t;
        has = 1;
        t   = trap_pc;
        if (trap_en)                    t = trap_pc;
        else if (m_pend && m_pend_trap) t = m_pend_tgt;
        else if (redirect_en)           t = redirect_pc;
        else if (m_pend)                t = m_pend_tgt;
        else                            has = 0;
        m_flush = redirect_en | trap_en;
        m_mis   = 0;
        if (!m_req || req_ready) begin
            // Idle, or the request is taken this cycle: the chosen target (if any) lands now.
            if (has) begin
                m_pc  = t - (t % 32'(ALGN));
                m_mis = (t % 32'(ALGN)) != 0;
            end else if (m_req) begin
                m_pc = m_pc + 32'd4;
            end
            m_pend = 0;
            m_req  = !stall;
        end else if (trap_en) begin
            m_pend = 1; m_pend_trap = 1; m_pend_tgt = trap_pc;
        end else if (redirect_en && !(m_pend && m_pend_trap)) begin
            m_pend = 1; m_pend_trap = 0; m_pend_tgt = redirect_pc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("req_valid", req_valid, m_req);
        check("req_pc",    req_pc,    m_pc);
        check("pc",        pc,        m_pc);
        check("pc_nxt",    pc_nxt,    m_pc + 32'd4);
        check("flush",     flush,     m_flush);
        check("misalign",  misalign,  m_mis);
        if (!rst) model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; redirect_en = 0; redirect_pc = '0;
        trap_en = 0; trap_pc = '0; req_ready = 1;
        model_reset();
        tick();
        tick();
        check("rst_valid", req_valid, 1'b0);
        check("rst_pc", pc, 32'h0);
        rst = 0;

        // Boot then sequential fetch
        tick();
        check("t1_pc0", req_pc, 32'h0);
        check("t1_valid", req_valid, 1'b1);
        tick(); check("t1_pc4", req_pc, 32'h4);
        tick(); check("t1_pc8", req_pc, 32'h8);
        tick(); check("t1_pcc", req_pc, 32'hC);
        tick(); check("t1_pc10", req_pc, 32'h10);

        // Redirect held while memory is not ready
        req_ready = 0; redirect_en = 1; redirect_pc = 32'h80;
        tick();
        redirect_en = 0;
        check("t2_hold_pc", req_pc, 32'h10);
        check("t2_flush", flush, 1'b1);
        tick();
        check("t2_flush_once", flush, 1'b0);
        check("t2_hold_valid", req_valid, 1'b1);
        tick();
        req_ready = 1;
        tick(); check("t2_tgt", pc, 32'h80);
        tick(); check("t2_after", pc, 32'h84);

        // Pending trap survives a later redirect
        req_ready = 0; redirect_en = 1; redirect_pc = 32'h200; trap_en = 1; trap_pc = 32'h1000;
        tick();
        check("t3_flush1", flush, 1'b1);
        trap_en = 0; redirect_pc = 32'h300;
        tick();
        check("t3_flush2", flush, 1'b1);
        check("t3_hold_pc", pc, 32'h84);
        redirect_en = 0; req_ready = 1;
        tick();
        check("t3_trap_pc", pc, 32'h1000);

        // Stall after accept, misaligned redirect in WAIT
        redirect_en = 1; redirect_pc = 32'h20;
        tick(); check("t4_pc20", pc, 32'h20);
        redirect_en = 0; stall = 1;
        tick();
        check("t4_wait_valid", req_valid, 1'b0);
        check("t4_pc24", pc, 32'h24);
        redirect_en = 1; redirect_pc = 32'h43;
        tick();
        check("t4_aligned", pc, 32'h40);
        check("t4_misalign", misalign, 1'b1);
        redirect_en = 0;
        tick();
        check("t4_mis_pulse", misalign, 1'b0);
        stall = 0;
        tick();
        check("t4_req40", req_pc, 32'h40);
        check("t4_valid", req_valid, 1'b1);

        // Address wrap
        trap_en = 1; trap_pc = 32'hFFFF_FFFC;
        tick();
        check("t5_top", pc, 32'hFFFF_FFFC);
        check("t5_nxt", pc_nxt, 32'h0);
        trap_en = 0;
        tick(); check("t5_wrap", req_pc, 32'h0);

        // Reset during a held request with a pending redirect
        req_ready = 0; redirect_en = 1; redirect_pc = 32'h500;
        tick();
        redirect_en = 0;
        #2;
        rst = 1;
        model_reset();
        #1;
        check("t6_valid_drop", req_valid, 1'b0);
        check("t6_flush_clr", flush, 1'b0);
        tick();
        tick();
        rst = 0; req_ready = 1;
        tick();
        check("t6_pc_boot", pc, 32'h0);
        check("t6_no_flush", flush, 1'b0);
        check("t6_no_mis", misalign, 1'b0);
        tick();
        check("t6_no_pend", pc, 32'h4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom % 4) == 0;
            req_ready   = ($urandom % 3) != 0;
            redirect_en = ($urandom % 6) == 0;
            trap_en     = ($urandom % 10) == 0;
            redirect_pc = $urandom;
            trap_pc     = (($urandom % 8) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            tick();
        end
        stall = 0; redirect_en = 0; trap_en = 0; req_ready = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_gen.md
Name: pc_fetch_gen

Overview:
- Parametrised program-counter and fetch-request generator; front of the pipeline, feeding instruction memory.
- Holds the architectural fetch PC and issues one fetch request per cycle over a valid/ready handshake.
- Accepts branch/jump redirects from EX and trap redirects from the trap unit, both with a defined priority.
- Pipeline stalls pause issue. A flush pulse tells IF/ID to discard stale fetches.

Parameters:
XLEN, 32, width of all PC/address signals.
RESET_VEC, 0, PC value loaded on reset (XLEN bits).
PC_INC, 4, sequential increment added per accepted fetch.
ALIGN_BITS, 2, number of PC LSBs that must be zero; 0 disables the alignment check.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
stall  in  1  downstream backpressure; blocks new requests after the current one completes.
redirect_en  in  1  branch/jump taken this cycle (from EX).
redirect_pc  in  XLEN  branch/jump target.
trap_en  in  1  trap/exception redirect this cycle.
trap_pc  in  XLEN  trap handler target.
req_valid  out  1  fetch request valid.
req_ready  in  1  instruction memory accepts the request.
req_pc  out  XLEN  fetch address; equals pc.
pc  out  XLEN  current fetch PC register.
pc_nxt  out  XLEN  pc + PC_INC, combinational, modulo 2^XLEN.
flush  out  1  one-cycle registered pulse: discard in-flight/just-fetched instructions.
misalign  out  1  one-cycle registered pulse: applied target had nonzero low ALIGN_BITS.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_VEC, state=BOOT, req_valid=0.
  - flush=0, misalign=0, pending flags cleared.
- States:
  - BOOT: req_valid=0. Next cycle goes to FETCH, or WAIT if stall=1.
  - FETCH: req_valid=1. Stays in FETCH until accept = req_valid & req_ready.
  - WAIT: req_valid=0. Goes to FETCH on the first cycle stall=0.
- Handshake:
  - Once req_valid=1, it stays high and req_pc stays stable until accept.
  - stall never drops an issued request.
- Accept in FETCH:
  - pc <= target if a redirect is arriving or pending, else pc_nxt.
  - Then go to WAIT if stall=1 that cycle, else remain in FETCH.
  - Back-to-back accepts give one fetch per cycle.
- Redirect in FETCH without accept:
  - Latch the redirect into a pending register; pc and req_pc are unchanged.
  - The target is applied at the next accept.
- Redirect in BOOT or WAIT:
  - pc <= target on the next edge; no pending entry is created.
- Priority:
  - Arriving trap > pending trap > arriving redirect > pending redirect.
  - A pending trap is never overwritten by a redirect.
  - A newer trap overwrites a pending trap.
  - A newer redirect overwrites a pending redirect.
  - When trap_en and redirect_en are high together, redirect is ignored.
- flush:
  - Asserted for exactly one cycle, in the cycle after any cycle where redirect_en|trap_en=1.
  - Asserted regardless of state.
  - Consecutive redirects give consecutive flush cycles.
- Alignment:
  - Target low ALIGN_BITS are forced to zero before loading pc.
  - misalign pulses for one cycle, aligned with the cycle pc takes the target.
  - Sequential increments are never checked.
- Arithmetic:
  - All adds are XLEN-bit and wrap modulo 2^XLEN.
  - pc=2^XLEN-PC_INC gives pc_nxt=0.
- Reset mid-request:
  - req_valid falls immediately and the pending redirect is discarded.
  - No flush or misalign pulse is produced.

Test Plan:
1. Release reset with RESET_VEC=0, req_ready=1, stall=0 -> BOOT for 1 cycle; then req_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles; pc_nxt always pc+4.
2. Hold req_ready=0 for 3 cycles at pc=0x10 with redirect_en=1, redirect_pc=0x80 in the first of them -> req_pc stays 0x10 with req_valid=1; flush pulses once; on accept pc becomes 0x80, then 0x84.
3. Same cycle redirect_en=1 (0x200) and trap_en=1 (0x1000) while pending, then redirect 0x300 the next cycle -> the pending trap is kept; after accept pc=0x1000; flush high 2 consecutive cycles.
4. stall=1 during accept at pc=0x20 -> req_valid=0 from the next cycle, pc=0x24; redirect 0x43 arrives in WAIT -> pc=0x40 next edge with misalign=1; after stall drops, req_pc=0x40.
5. XLEN=32 with pc preloaded to 0xFFFFFFFC via trap and accept -> next req_pc=0x00000000.
6. Assert rst while req_valid=1, req_ready=0 with a pending redirect -> req_valid=0 immediately; after release pc=RESET_VEC, no flush or misalign pulse, pending target never applied.
